// File: rtl/vend_controller_if.sv
// Front-end/datapath bundle for the vending sequencer: strobes and acks in,
// dispenser/hopper requests, credit, state and error pulses out.
interface vend_controller_if;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic [3:0] stock_empty;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic [7:0] credit;
  logic [2:0] state;
  logic       coin_reject;
  logic       err_insufficient;
  logic       err_sold_out;

  modport master (
    output coin_valid, coin_code, sel_valid, sel_id, cancel, stock_empty, disp_ack, chg_ack,
    input  disp_req, disp_id, chg_req, credit, state, coin_reject, err_insufficient, err_sold_out
  );

  modport slave (
    input  coin_valid, coin_code, sel_valid, sel_id, cancel, stock_empty, disp_ack, chg_ack,
    output disp_req, disp_id, chg_req, credit, state, coin_reject, err_insufficient, err_sold_out
  );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, selection checks, dispense
// handshake and nickel-by-nickel change payout. All outputs registered.
module vend_controller #(
  parameter int unsigned PRICE0  = 25,
  parameter int unsigned PRICE1  = 50,
  parameter int unsigned PRICE2  = 75,
  parameter int unsigned PRICE3  = 100,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  vend_controller_if.slave  bus_if
);
  localparam int unsigned CREDIT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCUM    = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3
  } state_e;

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                disp_req_q;
  logic [1:0]          disp_id_q;
  logic                chg_req_q;
  logic                coin_reject_q;
  logic                err_ins_q;
  logic                err_sold_q;

  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] credit_after_disp;
  logic                timeout_hit;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = CREDIT_W'(PRICE0);
      2'd1:    price_of = CREDIT_W'(PRICE1);
      2'd2:    price_of = CREDIT_W'(PRICE2);
      default: price_of = CREDIT_W'(PRICE3);
    endcase
  endfunction

  // Coin value, overflow-safe sum, and price lookups feeding the FSM.
  always_comb begin
    coin_amt = '0;
    case (bus_if.coin_code)
      2'd0:    coin_amt = CREDIT_W'(5);
      2'd1:    coin_amt = CREDIT_W'(10);
      2'd2:    coin_amt = CREDIT_W'(25);
      default: coin_amt = '0;
    endcase
    coin_sum          = {1'b0, credit_q} + {1'b0, coin_amt};
    coin_ok           = (coin_amt != '0) && !coin_sum[CREDIT_W];
    sel_price         = price_of(bus_if.sel_id);
    credit_after_disp = credit_q - price_of(disp_id_q);
    timeout_hit       = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      cnt_q         <= '0;
      disp_req_q    <= 1'b0;
      disp_id_q     <= 2'd0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      err_ins_q     <= 1'b0;
      err_sold_q    <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      err_ins_q     <= 1'b0;
      err_sold_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          // cnt_q counts idle cycles spent in ACCUM since the last strobe
          cnt_q <= (state_q == ST_ACCUM) ? cnt_q + CNT_W'(1) : '0;
          if (bus_if.cancel) begin
            cnt_q <= '0;
            if (credit_q != '0) begin
              state_q   <= ST_CHANGE;
              chg_req_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (bus_if.coin_valid) begin
            cnt_q <= '0;
            if (coin_ok) begin
              credit_q <= coin_sum[CREDIT_W-1:0];
              state_q  <= ST_ACCUM;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end else if (bus_if.sel_valid) begin
            cnt_q <= '0;
            if (bus_if.stock_empty[bus_if.sel_id]) begin
              err_sold_q <= 1'b1;
            end else if (credit_q < sel_price) begin
              err_ins_q <= 1'b1;
            end else begin
              state_q    <= ST_DISPENSE;
              disp_req_q <= 1'b1;
              disp_id_q  <= bus_if.sel_id;
            end
          end else if (state_q == ST_ACCUM && timeout_hit) begin
            cnt_q     <= '0;
            state_q   <= ST_CHANGE;
            chg_req_q <= (credit_q != '0);
          end
        end
        ST_DISPENSE: begin
          cnt_q         <= '0;
          coin_reject_q <= bus_if.coin_valid;
          if (bus_if.disp_ack) begin
            credit_q   <= credit_after_disp;
            disp_req_q <= 1'b0;
            if (credit_after_disp != '0) begin
              state_q   <= ST_CHANGE;
              chg_req_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_CHANGE: begin
          cnt_q         <= '0;
          coin_reject_q <= bus_if.coin_valid;
          if (credit_q == '0) begin
            chg_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (chg_req_q && bus_if.chg_ack) begin
            // Drop the request for one cycle after each nickel is released
            credit_q  <= credit_q - CREDIT_W'(5);
            chg_req_q <= 1'b0;
            if (credit_q == CREDIT_W'(5)) state_q <= ST_IDLE;
          end else begin
            chg_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          disp_req_q <= 1'b0;
          chg_req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.disp_req         = disp_req_q;
  assign bus_if.disp_id          = disp_id_q;
  assign bus_if.chg_req          = chg_req_q;
  assign bus_if.credit           = credit_q;
  assign bus_if.state            = state_q;
  assign bus_if.coin_reject      = coin_reject_q;
  assign bus_if.err_insufficient = err_ins_q;
  assign bus_if.err_sold_out     = err_sold_q;

endmodule
